// File: rtl/wb3_req_master_if.sv
// Signal bundle between a request/response client, the wb3_req_master and the
// I2C core's Wishbone B3 slave port.
interface wb3_req_master_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_we;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_we_o;
  logic                  wb_stb_o;
  logic                  wb_cyc_o;
  logic                  wb_ack_i;
  logic                  wb_inta_i;
  logic                  irq_o;

  // The bus master's view: drives the Wishbone outputs and the response port.
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
           wb_dat_i, wb_ack_i, wb_inta_i,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
           wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, irq_o
  );

  // The surrounding world's view: request source, response sink and Wishbone slave.
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
           wb_dat_i, wb_ack_i, wb_inta_i,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
           wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, irq_o
  );
endinterface

// File: rtl/wb3_req_master.sv
// Queues register read/write requests and replays each one as a classic Wishbone B3
// single cycle, returning exactly one response per request in request order.
module wb3_req_master #(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  wb3_req_master_if.master bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [1:0]         state;
  logic [TMO_W-1:0]   tmo_cnt;

  // Ready comes only from the registered full flag, so a pop on the same edge
  // never opens room for a push while full.
  assign push          = bus.req_valid & ~full;
  assign pop           = (state == IDLE) && (count != '0);
  assign head          = fifo_mem[rd_ptr];
  assign bus.req_ready = ~full;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.req_we, bus.req_addr, bus.req_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == CNT_W'(FIFO_DEPTH));
    end
  end

  // Bus owner FSM. The RESP hand-off plus the IDLE pop give two dead cycles
  // between strobes, so a registered-ack slave cannot ack the next cycle early.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      bus.wb_adr_o  <= '0;
      bus.wb_dat_o  <= '0;
      bus.wb_we_o   <= 1'b0;
      bus.wb_cyc_o  <= 1'b0;
      bus.wb_stb_o  <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_we    <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus.wb_we_o  <= head[ENTRY_W-1];
            bus.wb_adr_o <= head[DATA_WIDTH +: ADDR_WIDTH];
            bus.wb_dat_o <= head[DATA_WIDTH-1:0];
            bus.wb_cyc_o <= 1'b1;
            bus.wb_stb_o <= 1'b1;
            tmo_cnt      <= '0;
            state        <= BUS;
          end
        end
        BUS: begin
          if (bus.wb_ack_i) begin
            bus.rsp_rdata <= bus.wb_we_o ? '0 : bus.wb_dat_i;
            bus.rsp_err   <= 1'b0;
            bus.rsp_we    <= bus.wb_we_o;
            bus.rsp_valid <= 1'b1;
            bus.wb_cyc_o  <= 1'b0;
            bus.wb_stb_o  <= 1'b0;
            state         <= RESP;
          end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_we    <= bus.wb_we_o;
            bus.rsp_valid <= 1'b1;
            bus.wb_cyc_o  <= 1'b0;
            bus.wb_stb_o  <= 1'b0;
            state         <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.irq_o <= 1'b0;
    end else begin
      bus.irq_o <= bus.wb_inta_i;
    end
  end

endmodule

// File: tb/tb_wb3_req_master.sv
// Bench for wb3_req_master: a wait-state-configurable register-file slave plus a
// request-level reference model predicting each response.
module tb_wb3_req_master;
  localparam int AW  = 3;
  localparam int DW  = 8;
  localparam int TMO = 16;

  typedef struct {
    bit         we;
    logic [7:0] rdata;
    bit         err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb3_req_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb3_req_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;
  int cyc_n  = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Core register file model: acks after slave_wait extra sampled edges, or never.
  logic [7:0] core_mem [8] = '{default: 8'h00};
  logic       slave_ack = 1'b0;
  logic [7:0] slave_dat = 8'h00;
  logic       stray_ack = 1'b0;
  int         wcnt = 0;
  int         slave_wait = 0;
  bit         slave_mute = 1'b0;

  assign bus.wb_ack_i = slave_ack | stray_ack;
  assign bus.wb_dat_i = slave_dat;

  always @(posedge clk) begin
    if (bus.wb_cyc_o && bus.wb_stb_o && !slave_ack && !slave_mute) begin
      if (wcnt >= slave_wait) begin
        slave_ack <= 1'b1;
        wcnt      <= 0;
        if (bus.wb_we_o) core_mem[bus.wb_adr_o] <= bus.wb_dat_o;
        else slave_dat <= core_mem[bus.wb_adr_o];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      slave_ack <= 1'b0;
      if (!(bus.wb_cyc_o && bus.wb_stb_o)) wcnt <= 0;
    end
  end

  // Reference model: a cycle errors when the slave's ack cannot land inside the
  // timeout window; reads return the last successfully written value.
  logic [7:0] ref_mem [8] = '{default: 8'h00};
  rsp_t       exp_q[$];

  function automatic void model_req(bit we, logic [2:0] a, logic [7:0] d);
    rsp_t r;
    r.we    = we;
    r.err   = slave_mute || (slave_wait >= TMO - 1);
    r.rdata = (r.err || we) ? 8'h00 : ref_mem[a];
    if (we && !r.err) ref_mem[a] = d;
    exp_q.push_back(r);
  endfunction

  task automatic push_req(input bit we, input logic [2:0] a, input logic [7:0] d, output bit ok);
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = bus.req_ready;
    if (ok) begin
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      model_req(we, a, d);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic get_rsp(output bit ok, output rsp_t got);
    int n = 0;
    bus.rsp_ready = 1'b1;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok        = bus.rsp_valid;
    got.we    = bus.rsp_we;
    got.rdata = bus.rsp_rdata;
    got.err   = bus.rsp_err;
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0; bus.wb_inta_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_rdata} !== 12'h800)
      $display("[TB] FAIL reset_rsp: got %h expected 800",
               {bus.req_ready, bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_rdata});
    else passed++;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.irq_o} !== 15'h0)
      $display("[TB] FAIL reset_wb: got %h expected 0",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.irq_o});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.wb_cyc_o, bus.rsp_valid} !== 3'b100)
      $display("[TB] FAIL post_reset: got %b expected 100", {bus.req_ready, bus.wb_cyc_o, bus.rsp_valid});
    else passed++;
  endtask

  task automatic test_write_single();
    bit ok; rsp_t got, exp;
    bit seen = 1'b0, stable = 1'b1;
    bus.rsp_ready = 1'b1;
    push_req(1'b1, 3'h0, 8'h64, ok);
    checks++;
    if (ok !== 1'b1) $display("[TB] FAIL wr_push: got %b expected 1", ok); else passed++;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (bus.wb_stb_o) seen = 1'b1; else @(negedge clk);
    end
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o} !== {3'b111, 3'h0, 8'h64})
      $display("[TB] FAIL wr_bus: got %h expected %h",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o}, {3'b111, 3'h0, 8'h64});
    else passed++;
    for (int k = 0; k < 20 && bus.wb_cyc_o; k++) begin
      if ({bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o} !== {1'b1, 3'h0, 8'h64}) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (stable !== 1'b1) $display("[TB] FAIL wr_stable: got %b expected 1", stable); else passed++;
    get_rsp(ok, got);
    exp = exp_q.pop_front();
    checks++;
    if (ok !== 1'b1 || {got.we, got.rdata, got.err} !== {exp.we, exp.rdata, exp.err})
      $display("[TB] FAIL wr_rsp: got ok=%b %b/%h/%b expected 1 %b/%h/%b",
               ok, got.we, got.rdata, got.err, exp.we, exp.rdata, exp.err);
    else passed++;
  endtask

  task automatic test_read_latency();
    bit ok; rsp_t exp;
    int n_push, stb_at = -1, rsp_at = -1, low_at = -1;
    logic [7:0] rd = 8'h00;
    logic er = 1'b1;
    bus.rsp_ready = 1'b1;
    push_req(1'b0, 3'h0, 8'h00, ok);
    n_push = cyc_n;
    for (int k = 0; k < 10; k++) begin
      if (bus.wb_stb_o && stb_at < 0) stb_at = cyc_n;
      if (bus.rsp_valid && rsp_at < 0) begin
        rsp_at = cyc_n; rd = bus.rsp_rdata; er = bus.rsp_err;
      end else if (rsp_at >= 0 && !bus.rsp_valid && low_at < 0) begin
        low_at = cyc_n;
      end
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    checks++;
    if (stb_at !== n_push + 1) $display("[TB] FAIL lat_stb: got %0d expected %0d", stb_at, n_push + 1); else passed++;
    checks++;
    if (rsp_at !== n_push + 3) $display("[TB] FAIL lat_rsp: got %0d expected %0d", rsp_at, n_push + 3); else passed++;
    checks++;
    if (low_at !== n_push + 4) $display("[TB] FAIL lat_drop: got %0d expected %0d", low_at, n_push + 4); else passed++;
    checks++;
    if ({rd, er} !== {exp.rdata, exp.err} || rd !== 8'h64)
      $display("[TB] FAIL rd_prer: got %h/%b expected 64/%b", rd, er, exp.err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok; rsp_t got, exp;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_req(1'($urandom), 3'($urandom), 8'($urandom), ok);
      checks++;
      if (ok !== 1'b1) $display("[TB] FAIL b2b_push%0d: got %b expected 1", i, ok); else passed++;
    end
    checks++;
    if (bus.req_ready !== 1'b0) $display("[TB] FAIL b2b_full: got %b expected 0", bus.req_ready); else passed++;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      get_rsp(ok, got);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '{1'b0, 8'hxx, 1'b1};
      checks++;
      if (ok !== 1'b1 || {got.we, got.rdata, got.err} !== {exp.we, exp.rdata, exp.err})
        $display("[TB] FAIL b2b_rsp%0d: got ok=%b %b/%h/%b expected 1 %b/%h/%b",
                 i, ok, got.we, got.rdata, got.err, exp.we, exp.rdata, exp.err);
      else passed++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) $display("[TB] FAIL b2b_drain: got %b expected 1", bus.req_ready); else passed++;
  endtask

  task automatic test_timeout();
    bit ok; rsp_t got, exp;
    int stb_cnt = 0, n = 0;
    slave_mute = 1'b1;
    bus.rsp_ready = 1'b1;
    push_req(1'b0, 3'($urandom), 8'h00, ok);
    while (!bus.rsp_valid && n < 60) begin
      if (bus.wb_stb_o) stb_cnt++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (stb_cnt !== TMO) $display("[TB] FAIL tmo_stb_len: got %0d expected %0d", stb_cnt, TMO); else passed++;
    get_rsp(ok, got);
    exp = exp_q.pop_front();
    checks++;
    if (ok !== 1'b1 || {got.rdata, got.err} !== {exp.rdata, exp.err} || got.err !== 1'b1)
      $display("[TB] FAIL tmo_rsp: got ok=%b %h/%b expected 1 00/1", ok, got.rdata, got.err);
    else passed++;
    slave_mute = 1'b0;
    push_req(1'b0, 3'h0, 8'h00, ok);
    get_rsp(ok, got);
    exp = exp_q.pop_front();
    checks++;
    if (ok !== 1'b1 || {got.we, got.rdata, got.err} !== {exp.we, exp.rdata, exp.err})
      $display("[TB] FAIL tmo_recover: got ok=%b %b/%h/%b expected 1 %b/%h/%b",
               ok, got.we, got.rdata, got.err, exp.we, exp.rdata, exp.err);
    else passed++;
  endtask

  task automatic test_ack_boundary();
    bit ok, leak = 1'b0; rsp_t got, exp;
    int waits [3] = '{0, TMO - 2, TMO - 1};
    logic [7:0] d = 8'($urandom_range(1, 255));
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slave_wait = waits[i];
      push_req(i == 0, 3'h5, d, ok);
      get_rsp(ok, got);
      exp = exp_q.pop_front();
      checks++;
      if (ok !== 1'b1 || {got.we, got.rdata, got.err} !== {exp.we, exp.rdata, exp.err})
        $display("[TB] FAIL ack_wait%0d: got ok=%b %b/%h/%b expected 1 %b/%h/%b",
                 waits[i], ok, got.we, got.rdata, got.err, exp.we, exp.rdata, exp.err);
      else passed++;
    end
    slave_wait = 0;
    slave_mute = 1'b1;
    for (int i = 0; i < 3; i++) push_req(1'b0, 3'(i), 8'h00, ok);
    checks++;
    if (bus.wb_stb_o !== 1'b1) $display("[TB] FAIL rst_prebus: got %b expected 1", bus.wb_stb_o); else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid, bus.req_ready} !== 4'b0001)
      $display("[TB] FAIL rst_midbus: got %b expected 0001",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid, bus.req_ready});
    else passed++;
    rst = 1'b0;
    exp_q.delete();
    slave_mute = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus.rsp_valid || bus.wb_stb_o) leak = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (leak !== 1'b0) $display("[TB] FAIL rst_flush: got %b expected 0", leak); else passed++;
  endtask

  task automatic test_irq_and_stray();
    bit ok, leak = 1'b0; rsp_t got, exp;
    bus.wb_inta_i = 1'b1;
    #1;
    checks++;
    if (bus.irq_o !== 1'b0) $display("[TB] FAIL irq_early: got %b expected 0", bus.irq_o); else passed++;
    @(negedge clk);
    checks++;
    if (bus.irq_o !== 1'b1) $display("[TB] FAIL irq_rise: got %b expected 1", bus.irq_o); else passed++;
    bus.wb_inta_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.irq_o !== 1'b0) $display("[TB] FAIL irq_fall: got %b expected 0", bus.irq_o); else passed++;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.rsp_valid || bus.wb_stb_o) leak = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (leak !== 1'b0) $display("[TB] FAIL idle_ack: got %b expected 0", leak); else passed++;
    push_req(1'b0, 3'h5, 8'h00, ok);
    get_rsp(ok, got);
    exp = exp_q.pop_front();
    checks++;
    if (ok !== 1'b1 || {got.we, got.rdata, got.err} !== {exp.we, exp.rdata, exp.err})
      $display("[TB] FAIL idle_ack_next: got ok=%b %b/%h/%b expected 1 %b/%h/%b",
               ok, got.we, got.rdata, got.err, exp.we, exp.rdata, exp.err);
    else passed++;
  endtask

  task automatic test_random();
    slave_wait = $urandom_range(0, 3);
    fork
      begin
        bit ok;
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          push_req(1'($urandom), 3'($urandom), 8'($urandom), ok);
        end
      end
      begin
        bit ok; rsp_t got, exp;
        for (int i = 0; i < 24; i++) begin
          get_rsp(ok, got);
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : '{1'b0, 8'hxx, 1'b1};
          checks++;
          if (ok !== 1'b1 || {got.we, got.rdata, got.err} !== {exp.we, exp.rdata, exp.err})
            $display("[TB] FAIL rand_rsp%0d: got ok=%b %b/%h/%b expected 1 %b/%h/%b",
                     i, ok, got.we, got.rdata, got.err, exp.we, exp.rdata, exp.err);
          else passed++;
        end
      end
    join
    slave_wait = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write_single();
    test_read_latency();
    test_back_to_back();
    test_timeout();
    test_ack_boundary();
    test_irq_and_stray();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
